// File: rtl/thr_peak_detect_if.sv
// Load/commit/control inputs and filter/peak outputs of thr_peak_detect.
// Master drives the load chunks, commit and control. Slave is the detector.
// Every signal is a plain wire; the only flow control is the commit strobe.
interface thr_peak_detect_if #(
  parameter int DW   = 8,
  parameter int NIB  = 4,
  parameter int CNTW = 8
);
  localparam int NCH = DW / NIB;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic            ld_en;
  logic [1:0]      ld_tgt;
  logic [IW-1:0]   ld_idx;
  logic [NIB-1:0]  ld_data;
  logic            smp_commit;
  logic            mode;
  logic            cnt_clr;
  logic [DW-1:0]   fop;
  logic            pass;
  logic            peak;
  logic [DW-1:0]   peak_val;
  logic [CNTW-1:0] peak_cnt;
  logic            busy;

  modport master (
    output ld_en, ld_tgt, ld_idx, ld_data, smp_commit, mode, cnt_clr,
    input  fop, pass, peak, peak_val, peak_cnt, busy
  );

  modport slave (
    input  ld_en, ld_tgt, ld_idx, ld_data, smp_commit, mode, cnt_clr,
    output fop, pass, peak, peak_val, peak_cnt, busy
  );
endinterface

// File: rtl/thr_peak_detect.sv
// Threshold filter plus hysteresis peak detector with refractory window.
// Latency: fop/pass 1 cycle after smp_commit, peak 2 cycles after smp_commit.
// No backpressure: a commit is accepted on every cycle it is asserted.
module thr_peak_detect #(
  parameter int DW     = 8,
  parameter int NIB    = 4,
  parameter int REFRAC = 16,
  parameter int CNTW   = 8
) (
  input logic clk,
  input logic rst,
  thr_peak_detect_if.slave bus
);
  localparam int NCH = DW / NIB;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RISE,
    S_REFRACT
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   smp_asm, th, hyst;
  logic [DW-1:0]   fop_q, cur, max_q, max_nx;
  logic [DW-1:0]   peak_val_q, peak_val_nx;
  logic [DW-1:0]   drop;
  logic            pass_q, fv;
  logic            peak_q, peak_nx, cnt_inc;
  logic [RW-1:0]   rcnt, rcnt_nx;
  logic [CNTW-1:0] cnt_q;

  // Chunk loads into the sample assembly, threshold and hysteresis registers.
  // Indices past the last chunk never match and so are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_asm <= '0;
      th      <= '0;
      hyst    <= '0;
    end else if (bus.ld_en) begin
      for (int k = 0; k < NCH; k++) begin
        if (bus.ld_idx == IW'(k)) begin
          case (bus.ld_tgt)
            2'b00:   smp_asm[k*NIB +: NIB] <= bus.ld_data;
            2'b01:   th[k*NIB +: NIB]      <= bus.ld_data;
            2'b10:   hyst[k*NIB +: NIB]    <= bus.ld_data;
            default: ;
          endcase
        end
      end
    end
  end

  // Commit: compare the pre-edge sample against the pre-edge threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      fop_q  <= '0;
      cur    <= '0;
      fv     <= 1'b0;
    end else begin
      fv <= bus.smp_commit;
      if (bus.smp_commit) begin
        cur    <= smp_asm;
        pass_q <= (smp_asm > th);
        if (smp_asm > th) begin
          fop_q <= smp_asm;
        end else if (bus.mode) begin
          fop_q <= '0;
        end
      end
    end
  end

  // Peak FSM next state: only a freshly committed sample (fv) moves it.
  always_comb begin
    state_nx    = state;
    max_nx      = max_q;
    rcnt_nx     = rcnt;
    peak_nx     = 1'b0;
    peak_val_nx = peak_val_q;
    cnt_inc     = 1'b0;
    drop        = max_q - cur;
    if (fv) begin
      case (state)
        S_IDLE: begin
          if (pass_q) begin
            max_nx   = cur;
            state_nx = S_RISE;
          end
        end
        S_RISE: begin
          if (pass_q && (cur > max_q)) begin
            max_nx = cur;
          end else if (!pass_q || ((cur < max_q) && (drop >= hyst))) begin
            peak_nx     = 1'b1;
            peak_val_nx = max_q;
            cnt_inc     = 1'b1;
            if (REFRAC == 0) begin
              state_nx = S_IDLE;
            end else begin
              state_nx = S_REFRACT;
              rcnt_nx  = RW'(REFRAC);
            end
          end
        end
        S_REFRACT: begin
          // The sample that finds rcnt at zero is consumed, not evaluated.
          if (rcnt == '0) begin
            state_nx = S_IDLE;
          end else begin
            rcnt_nx = rcnt - RW'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Peak FSM registers, including the one-cycle peak pulse and its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      max_q      <= '0;
      rcnt       <= '0;
      peak_q     <= 1'b0;
      peak_val_q <= '0;
    end else begin
      state      <= state_nx;
      max_q      <= max_nx;
      rcnt       <= rcnt_nx;
      peak_q     <= peak_nx;
      peak_val_q <= peak_val_nx;
    end
  end

  // Saturating beat counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign bus.fop      = fop_q;
  assign bus.pass     = pass_q;
  assign bus.peak     = peak_q;
  assign bus.peak_val = peak_val_q;
  assign bus.peak_cnt = cnt_q;
  assign bus.busy     = (state != S_IDLE);
endmodule

// File: tb/tb_thr_peak_detect.sv
// Self-checking bench for thr_peak_detect: filter vector table, hand-built
// peak/refractory/saturation/reset sequences, then a randomized run checked
// every cycle against a rule-level reference model.
module tb_thr_peak_detect;
  localparam int DW     = 8;
  localparam int NIB    = 4;
  localparam int REFRAC = 2;
  localparam int CNTW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thr_peak_detect_if #(.DW(DW), .NIB(NIB), .CNTW(CNTW)) bus ();

  thr_peak_detect #(.DW(DW), .NIB(NIB), .REFRAC(REFRAC), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_en      = 1'b0;
    bus.ld_tgt     = 2'b00;
    bus.ld_idx     = '0;
    bus.ld_data    = '0;
    bus.smp_commit = 1'b0;
    bus.cnt_clr    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.mode = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Write an 8-bit value as two nibble chunks into the chosen target.
  task automatic load(input logic [1:0] tgt, input logic [7:0] val);
    for (int k = 0; k < 2; k++) begin
      bus.ld_en   = 1'b1;
      bus.ld_tgt  = tgt;
      bus.ld_idx  = 1'(k);
      bus.ld_data = val[k*4 +: 4];
      step();
    end
    bus.ld_en = 1'b0;
  endtask

  // Assemble and commit one sample, then spend the evaluation cycle
  // (optionally with cnt_clr) and report the peak seen after it.
  task automatic commit_s(input logic [7:0] val, input logic clr, output logic pk);
    load(2'b00, val);
    bus.smp_commit = 1'b1;
    step();
    bus.smp_commit = 1'b0;
    bus.cnt_clr    = clr;
    step();
    pk = bus.peak;
    bus.cnt_clr = 1'b0;
  endtask

  // Three ignored samples close the refractory window, then one beat.
  task automatic beat(input logic clr, output logic pk);
    logic p;
    for (int i = 0; i < 3; i++) commit_s(8'h10, 1'b0, p);
    commit_s(8'h50, 1'b0, p);
    commit_s(8'h10, clr, pk);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_asm, m_th, m_hyst, m_fop, m_cur, m_pv, m_max;
  logic       m_pass, m_fv, m_peak, in_beat;
  int         ignore_left;
  int         m_cnt;

  task automatic model_reset();
    m_asm = 0; m_th = 0; m_hyst = 0; m_fop = 0; m_cur = 0; m_pv = 0; m_max = 0;
    m_pass = 0; m_fv = 0; m_peak = 0; in_beat = 0; ignore_left = 0; m_cnt = 0;
  endtask

  // One clock edge worth of behaviour, from the pre-edge state and inputs.
  task automatic model_step();
    logic pk;
    pk = 1'b0;
    if (m_fv) begin
      if (ignore_left > 0) begin
        ignore_left--;
      end else if (!in_beat) begin
        if (m_pass) begin
          in_beat = 1'b1;
          m_max   = m_cur;
        end
      end else if (m_pass && m_cur > m_max) begin
        m_max = m_cur;
      end else if (!m_pass || (m_cur < m_max && int'(m_max) - int'(m_cur) >= int'(m_hyst))) begin
        pk          = 1'b1;
        m_pv        = m_max;
        in_beat     = 1'b0;
        ignore_left = (REFRAC > 0) ? REFRAC + 1 : 0;
      end
    end
    m_peak = pk;
    if (bus.cnt_clr) m_cnt = 0;
    else if (pk && m_cnt < (1 << CNTW) - 1) m_cnt++;
    m_fv = bus.smp_commit;
    if (bus.smp_commit) begin
      m_cur  = m_asm;
      m_pass = (m_asm > m_th);
      if (m_pass) m_fop = m_asm;
      else if (bus.mode) m_fop = 8'h00;
    end
    if (bus.ld_en) begin
      case (bus.ld_tgt)
        2'b00: m_asm  = (m_asm  & ~(8'hF << (4 * bus.ld_idx))) | (8'(bus.ld_data) << (4 * bus.ld_idx));
        2'b01: m_th   = (m_th   & ~(8'hF << (4 * bus.ld_idx))) | (8'(bus.ld_data) << (4 * bus.ld_idx));
        2'b10: m_hyst = (m_hyst & ~(8'hF << (4 * bus.ld_idx))) | (8'(bus.ld_data) << (4 * bus.ld_idx));
        default: ;
      endcase
    end
  endtask

  typedef struct packed {
    logic [7:0] th;
    logic [7:0] smp;
    logic       mode;
    logic       pass;
    logic [7:0] fop;
  } fvec_t;

  fvec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic pk;
    logic [1:0] r;

    tbl[0] = '{8'h64, 8'h64, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{8'h64, 8'h64, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{8'h64, 8'h80, 1'b0, 1'b1, 8'h80};
    tbl[3] = '{8'h64, 8'h10, 1'b0, 1'b0, 8'h80};
    tbl[4] = '{8'h64, 8'h80, 1'b1, 1'b1, 8'h80};
    tbl[5] = '{8'h64, 8'h10, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{8'h64, 8'h65, 1'b0, 1'b1, 8'h65};
    tbl[7] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'h65};
    tbl[8] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'h01};
    tbl[9] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h01};

    // Reset state and threshold load leave every output at zero.
    do_reset();
    load(2'b01, 8'h64);
    chk("rst_fop",   32'(bus.fop), 0);
    chk("rst_pass",  32'(bus.pass), 0);
    chk("rst_peak",  32'(bus.peak), 0);
    chk("rst_pval",  32'(bus.peak_val), 0);
    chk("rst_cnt",   32'(bus.peak_cnt), 0);
    chk("rst_busy",  32'(bus.busy), 0);

    // Filter vector table.
    for (int i = 0; i < 10; i++) begin
      load(2'b01, tbl[i].th);
      bus.mode = tbl[i].mode;
      commit_s(tbl[i].smp, 1'b0, pk);
      chk($sformatf("tbl%0d_pass", i), 32'(bus.pass), 32'(tbl[i].pass));
      chk($sformatf("tbl%0d_fop", i),  32'(bus.fop),  32'(tbl[i].fop));
    end

    // Peak with hysteresis: dip of 4 holds the beat, dip of 8 ends it.
    do_reset();
    load(2'b01, 8'h40);
    load(2'b10, 8'h08);
    commit_s(8'h50, 1'b0, pk); chk("hy_50_peak", 32'(pk), 0); chk("hy_50_busy", 32'(bus.busy), 1);
    commit_s(8'h70, 1'b0, pk); chk("hy_70_peak", 32'(pk), 0);
    commit_s(8'h6C, 1'b0, pk); chk("hy_6c_peak", 32'(pk), 0);
    commit_s(8'h68, 1'b0, pk); chk("hy_68_peak", 32'(pk), 1);
    chk("hy_pval", 32'(bus.peak_val), 32'h70);
    chk("hy_cnt",  32'(bus.peak_cnt), 1);
    step();
    chk("hy_pulse_width", 32'(bus.peak), 0);

    // Refractory window.
    commit_s(8'h90, 1'b0, pk); chk("rf_90_peak", 32'(pk), 0); chk("rf_90_busy", 32'(bus.busy), 1);
    commit_s(8'h20, 1'b0, pk); chk("rf_20_busy", 32'(bus.busy), 1);
    commit_s(8'h30, 1'b0, pk); chk("rf_30_busy", 32'(bus.busy), 0);
    commit_s(8'h50, 1'b0, pk); chk("rf_50_busy", 32'(bus.busy), 1);
    commit_s(8'h10, 1'b0, pk); chk("rf_10_peak", 32'(pk), 1);
    chk("rf_pval", 32'(bus.peak_val), 32'h50);
    chk("rf_cnt",  32'(bus.peak_cnt), 2);

    // Saturation at 3 and clear winning over a coincident increment.
    beat(1'b0, pk); chk("sat3_peak", 32'(pk), 1); chk("sat3_cnt", 32'(bus.peak_cnt), 3);
    beat(1'b0, pk); chk("sat4_peak", 32'(pk), 1); chk("sat4_cnt", 32'(bus.peak_cnt), 3);
    beat(1'b1, pk); chk("clr_peak",  32'(pk), 1); chk("clr_cnt",  32'(bus.peak_cnt), 0);

    // Asynchronous reset while rising aborts the beat with no pulse.
    for (int i = 0; i < 3; i++) commit_s(8'h10, 1'b0, pk);
    commit_s(8'h50, 1'b0, pk);
    chk("ar_busy_before", 32'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy_async", 32'(bus.busy), 0);
    chk("ar_peak_async", 32'(bus.peak), 0);
    step();
    rst = 1'b0;
    step();
    commit_s(8'h10, 1'b0, pk);
    chk("ar_no_peak", 32'(pk), 0);
    chk("ar_cnt",     32'(bus.peak_cnt), 0);
    chk("ar_pval",    32'(bus.peak_val), 0);

    // Same-cycle sample chunk write is not part of the committed sample.
    load(2'b01, 8'h40);
    load(2'b00, 8'h55);
    bus.ld_en = 1'b1; bus.ld_tgt = 2'b00; bus.ld_idx = 1'b0; bus.ld_data = 4'hF;
    bus.smp_commit = 1'b1;
    step();
    bus.ld_en = 1'b0;
    chk("sc_fop_old", 32'(bus.fop), 32'h55);
    step();
    bus.smp_commit = 1'b0;
    chk("sc_fop_new", 32'(bus.fop), 32'h5F);
    step();

    // Randomized run against the reference model, checked every cycle.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.ld_en = ($urandom_range(0, 3) != 0);
      r = 2'($urandom_range(0, 15));
      bus.ld_tgt     = (r != 2'b11 || $urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      bus.ld_idx     = 1'($urandom_range(0, 1));
      bus.ld_data    = 4'($urandom_range(0, 15));
      bus.smp_commit = ($urandom_range(0, 2) != 0);
      bus.cnt_clr    = ($urandom_range(0, 63) == 0);
      if (c % 200 == 0) bus.mode = 1'($urandom_range(0, 1));
      model_step();
      step();
      chk("rnd_fop",  32'(bus.fop),      32'(m_fop));
      chk("rnd_pass", 32'(bus.pass),     32'(m_pass));
      chk("rnd_peak", 32'(bus.peak),     32'(m_peak));
      chk("rnd_pval", 32'(bus.peak_val), 32'(m_pv));
      chk("rnd_cnt",  32'(bus.peak_cnt), 32'(m_cnt));
      chk("rnd_busy", 32'(bus.busy),     32'(in_beat || ignore_left > 0));
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
